// File: rtl/latch_output_monitor.sv
// -----------------------------------------------------------------------------
// latch_output_monitor
//   Clocked consumer of an asynchronous D-latch output pair (Q and its
//   complement P). Both inputs pass through flop synchronisers, Q is debounced
//   by a four-state FSM, and single-cycle rise/fall pulses are produced when
//   the debounced value changes. A separate tracker flags the illegal Q==P
//   condition after it persists, and a saturating counter tallies accepted
//   edges.
//
// Ports
//   clk         in   1          rising-edge clock for all state
//   rst_n       in   1          asynchronous active-low reset
//   q_in        in   1          latch Q, asynchronous to clk
//   p_in        in   1          latch P (complement), asynchronous to clk
//   clr_cnt     in   1          synchronous clear of edge_count / cnt_sat
//   q_db        out  1          debounced, synchronised Q
//   rise_pulse  out  1          one-cycle pulse on q_db 0->1
//   fall_pulse  out  1          one-cycle pulse on q_db 1->0
//   invalid     out  1          debounced Q==P fault flag
//   edge_count  out  CNT_WIDTH  saturating count of accepted edges
//   cnt_sat     out  1          edge_count is all-ones
// -----------------------------------------------------------------------------
module latch_output_monitor #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 q_in,
    input  logic                 p_in,
    input  logic                 clr_cnt,
    output logic                 q_db,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic                 invalid,
    output logic [CNT_WIDTH-1:0] edge_count,
    output logic                 cnt_sat
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value at which one more agreeing sample completes the debounce.
    localparam logic [DW-1:0]        DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0]        DCNT_ONE  = DW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_PEND_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_PEND_LO = 2'd3
    } db_state_t;

    logic [SYNC_STAGES-1:0] q_sync_r;
    logic [SYNC_STAGES-1:0] p_sync_r;
    logic                   q_s;
    logic                   valid_s;

    db_state_t              state_r, state_nx;
    logic [DW-1:0]          dcnt_r, dcnt_nx;
    logic [DW-1:0]          fcnt_r, fcnt_nx;
    logic                   invalid_r, invalid_nx;
    logic                   q_db_r, q_db_nx;
    logic                   rise_r, rise_nx;
    logic                   fall_r, fall_nx;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_nx, cnt_base_s;
    logic                   sat_r, sat_nx;

    assign q_s     = q_sync_r[SYNC_STAGES-1];
    assign valid_s = (q_sync_r[SYNC_STAGES-1] != p_sync_r[SYNC_STAGES-1]);

    // Synchroniser chains; reset to the legal "Q low" pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sync_r <= {SYNC_STAGES{1'b0}};
            p_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            q_sync_r <= {q_sync_r[SYNC_STAGES-2:0], q_in};
            p_sync_r <= {p_sync_r[SYNC_STAGES-2:0], p_in};
        end
    end

    // Debounce FSM next state; invalid samples never advance it.
    always_comb begin
        state_nx = state_r;
        dcnt_nx  = dcnt_r;
        case (state_r)
            ST_LOW: begin
                if (valid_s && q_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nx = ST_HIGH;
                        dcnt_nx  = '0;
                    end else begin
                        state_nx = ST_PEND_HI;
                        dcnt_nx  = DCNT_ONE;
                    end
                end else begin
                    dcnt_nx = '0;
                end
            end
            ST_PEND_HI: begin
                if (valid_s && q_s) begin
                    if (dcnt_r == DCNT_LAST) begin
                        state_nx = ST_HIGH;
                        dcnt_nx  = '0;
                    end else begin
                        dcnt_nx = dcnt_r + DCNT_ONE;
                    end
                end else begin
                    state_nx = ST_LOW;
                    dcnt_nx  = '0;
                end
            end
            ST_HIGH: begin
                if (valid_s && !q_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nx = ST_LOW;
                        dcnt_nx  = '0;
                    end else begin
                        state_nx = ST_PEND_LO;
                        dcnt_nx  = DCNT_ONE;
                    end
                end else begin
                    dcnt_nx = '0;
                end
            end
            ST_PEND_LO: begin
                if (valid_s && !q_s) begin
                    if (dcnt_r == DCNT_LAST) begin
                        state_nx = ST_LOW;
                        dcnt_nx  = '0;
                    end else begin
                        dcnt_nx = dcnt_r + DCNT_ONE;
                    end
                end else begin
                    state_nx = ST_HIGH;
                    dcnt_nx  = '0;
                end
            end
            default: begin
                state_nx = ST_LOW;
                dcnt_nx  = '0;
            end
        endcase
    end

    // Fault tracker: fcnt counts consecutive samples disagreeing with invalid.
    always_comb begin
        invalid_nx = invalid_r;
        fcnt_nx    = '0;
        if (valid_s == invalid_r) begin
            if (fcnt_r == DCNT_LAST) begin
                invalid_nx = !invalid_r;
                fcnt_nx    = '0;
            end else begin
                fcnt_nx = fcnt_r + DCNT_ONE;
            end
        end else begin
            fcnt_nx = '0;
        end
    end

    // Output decode, pulses and saturating edge counter (clear, then count).
    always_comb begin
        q_db_nx    = (state_nx == ST_HIGH) || (state_nx == ST_PEND_LO);
        rise_nx    = q_db_nx && !q_db_r;
        fall_nx    = !q_db_nx && q_db_r;
        cnt_base_s = clr_cnt ? '0 : cnt_r;
        if ((rise_nx || fall_nx) && (cnt_base_s != CNT_MAX)) begin
            cnt_nx = cnt_base_s + CNT_ONE;
        end else begin
            cnt_nx = cnt_base_s;
        end
        sat_nx = (cnt_nx == CNT_MAX);
    end

    // All state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_LOW;
            dcnt_r    <= '0;
            fcnt_r    <= '0;
            invalid_r <= 1'b0;
            q_db_r    <= 1'b0;
            rise_r    <= 1'b0;
            fall_r    <= 1'b0;
            cnt_r     <= '0;
            sat_r     <= 1'b0;
        end else begin
            state_r   <= state_nx;
            dcnt_r    <= dcnt_nx;
            fcnt_r    <= fcnt_nx;
            invalid_r <= invalid_nx;
            q_db_r    <= q_db_nx;
            rise_r    <= rise_nx;
            fall_r    <= fall_nx;
            cnt_r     <= cnt_nx;
            sat_r     <= sat_nx;
        end
    end

    assign q_db       = q_db_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;
    assign invalid    = invalid_r;
    assign edge_count = cnt_r;
    assign cnt_sat    = sat_r;

endmodule

// File: tb/tb_latch_output_monitor.sv
// -----------------------------------------------------------------------------
// tb_latch_output_monitor
//   Directed bench. Instance a uses default parameters, instance b uses
//   CNT_WIDTH=2 to exercise saturation. Both see the same latch inputs and
//   reset; each has its own clr_cnt.
// -----------------------------------------------------------------------------
module tb_latch_output_monitor;

    logic       clk;
    logic       rst_n;
    logic       q_in;
    logic       p_in;
    logic       clr_a;
    logic       clr_b;

    logic       q_db_a, rise_a, fall_a, inv_a, sat_a;
    logic [7:0] cnt_a;
    logic       q_db_b, rise_b, fall_b, inv_b, sat_b;
    logic [1:0] cnt_b;

    int checks;
    int errors;
    int pulses;

    latch_output_monitor dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .q_in       (q_in),
        .p_in       (p_in),
        .clr_cnt    (clr_a),
        .q_db       (q_db_a),
        .rise_pulse (rise_a),
        .fall_pulse (fall_a),
        .invalid    (inv_a),
        .edge_count (cnt_a),
        .cnt_sat    (sat_a)
    );

    latch_output_monitor #(.CNT_WIDTH(2)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .q_in       (q_in),
        .p_in       (p_in),
        .clr_cnt    (clr_b),
        .q_db       (q_db_b),
        .rise_pulse (rise_b),
        .fall_pulse (fall_b),
        .invalid    (inv_b),
        .edge_count (cnt_b),
        .cnt_sat    (sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_latch(input logic q, input logic p);
        q_in = q;
        p_in = p;
    endtask

    // Clean toggle of the latch; after 6 edges q_db follows with one pulse.
    task automatic toggle(input logic newq, input logic [7:0] exp_a,
                          input logic [1:0] exp_b, input logic exp_sat_b);
        set_latch(newq, !newq);
        step(5);
        check("tog_pre_qdb", {31'd0, q_db_a}, {31'd0, !newq});
        step(1);
        check("tog_qdb", {31'd0, q_db_a}, {31'd0, newq});
        check("tog_rise", {31'd0, rise_a}, {31'd0, newq});
        check("tog_fall", {31'd0, fall_a}, {31'd0, !newq});
        check("tog_cnt_a", {24'd0, cnt_a}, {24'd0, exp_a});
        check("tog_cnt_b", {30'd0, cnt_b}, {30'd0, exp_b});
        check("tog_sat_b", {31'd0, sat_b}, {31'd0, exp_sat_b});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clr_a  = 1'b0;
        clr_b  = 1'b0;
        set_latch(1'b0, 1'b1);
        step(3);
        check("rst_qdb", {31'd0, q_db_a}, 32'd0);
        check("rst_cnt", {24'd0, cnt_a}, 32'd0);
        check("rst_inv", {31'd0, inv_a}, 32'd0);
        rst_n = 1'b1;

        // 1: idle after reset
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            pulses += int'(rise_a) + int'(fall_a) + int'(inv_a) + int'(q_db_a) + int'(sat_a);
        end
        check("idle_activity", pulses, 32'd0);
        check("idle_cnt", {24'd0, cnt_a}, 32'd0);

        // 2: clean rise, then clean fall
        toggle(1'b1, 8'd1, 2'd1, 1'b0);
        step(1);
        check("rise_one_cycle", {31'd0, rise_a}, 32'd0);
        check("rise_hold_qdb", {31'd0, q_db_a}, 32'd1);
        toggle(1'b0, 8'd2, 2'd2, 1'b0);
        step(1);
        check("fall_one_cycle", {31'd0, fall_a}, 32'd0);

        // 3: 3-cycle glitch is rejected
        set_latch(1'b1, 1'b0);
        step(3);
        set_latch(1'b0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            pulses += int'(rise_a) + int'(fall_a) + int'(q_db_a);
        end
        check("glitch_activity", pulses, 32'd0);
        check("glitch_cnt", {24'd0, cnt_a}, 32'd2);

        // 4: Q==P fault, then recovery to a valid high
        set_latch(1'b1, 1'b1);
        step(5);
        check("flt_pre", {31'd0, inv_a}, 32'd0);
        step(1);
        check("flt_set", {31'd0, inv_a}, 32'd1);
        check("flt_qdb", {31'd0, q_db_a}, 32'd0);
        step(4);
        check("flt_hold", {31'd0, inv_a}, 32'd1);
        check("flt_qdb_hold", {31'd0, q_db_a}, 32'd0);
        set_latch(1'b1, 1'b0);
        step(5);
        check("rec_pre_inv", {31'd0, inv_a}, 32'd1);
        check("rec_pre_qdb", {31'd0, q_db_a}, 32'd0);
        step(1);
        check("rec_inv", {31'd0, inv_a}, 32'd0);
        check("rec_qdb", {31'd0, q_db_a}, 32'd1);
        check("rec_rise", {31'd0, rise_a}, 32'd1);
        check("rec_cnt", {24'd0, cnt_a}, 32'd3);

        // 5: saturation on the 2-bit instance; clear only instance b first
        step(1);
        check("presat_b", {30'd0, cnt_b}, 32'd3);
        clr_b = 1'b1;
        step(1);
        clr_b = 1'b0;
        check("clr_cnt_b", {30'd0, cnt_b}, 32'd0);
        check("clr_sat_b", {31'd0, sat_b}, 32'd0);
        check("clr_cnt_a_kept", {24'd0, cnt_a}, 32'd3);
        toggle(1'b0, 8'd4, 2'd1, 1'b0);
        toggle(1'b1, 8'd5, 2'd2, 1'b0);
        toggle(1'b0, 8'd6, 2'd3, 1'b1);
        toggle(1'b1, 8'd7, 2'd3, 1'b1);
        toggle(1'b0, 8'd8, 2'd3, 1'b1);
        // 6th edge with clr_cnt coincident with its pulse
        set_latch(1'b1, 1'b0);
        step(5);
        clr_b = 1'b1;
        step(1);
        clr_b = 1'b0;
        check("clrpulse_rise", {31'd0, rise_b}, 32'd1);
        check("clrpulse_cnt_b", {30'd0, cnt_b}, 32'd1);
        check("clrpulse_sat_b", {31'd0, sat_b}, 32'd0);
        check("clrpulse_cnt_a", {24'd0, cnt_a}, 32'd9);

        // 6: reset during PEND_HI with dcnt=2
        toggle(1'b0, 8'd10, 2'd2, 1'b0);
        set_latch(1'b1, 1'b0);
        step(4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", {24'd0, cnt_a}, 32'd0);
        check("mid_rst_qdb", {31'd0, q_db_a}, 32'd0);
        check("mid_rst_pulse", {31'd0, rise_a | fall_a}, 32'd0);
        step(2);
        rst_n = 1'b1;
        step(5);
        check("post_rst_pre", {31'd0, q_db_a}, 32'd0);
        step(1);
        check("post_rst_qdb", {31'd0, q_db_a}, 32'd1);
        check("post_rst_rise", {31'd0, rise_a}, 32'd1);
        check("post_rst_cnt", {24'd0, cnt_a}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
